// File: rtl/mix_pkg.sv
// Shared MIX datapath definitions: word layout, store-sequencer states,
// and the field-spec validity test.
package mix_pkg;

  localparam int unsigned MixWordW = 31;
  localparam int unsigned ByteW    = 6;
  localparam int unsigned NumBytes = 5;
  localparam int unsigned SignBit  = 30;

  // F = 8L+R for the whole word (0:5)
  localparam logic [5:0] FULL_FIELD = 6'o05;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWait,
    StWrite
  } state_e;

  // Field L:R is meaningful only when L <= R <= 5
  function automatic logic field_ok(input logic [5:0] f);
    return (f[5:3] <= f[2:0]) && (f[2:0] <= 3'd5);
  endfunction

  // LSB position of MIX byte k (1 = leftmost, 5 = rightmost)
  function automatic int unsigned byte_lsb(input int unsigned k);
    return (NumBytes - k) * ByteW;
  endfunction

endpackage

// File: rtl/store_seq_if.sv
// Store request and main-memory port bundle for store_seq.
// master: the sequencer side; slave: requester plus memory side.
interface store_seq_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned WORD_W = 31
) ();

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_reg;
  logic [5:0]        req_field;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_wr;
  logic [WORD_W-1:0] mem_wdata;

  logic              done;
  logic              err;

  modport master (
    input  req_valid, req_addr, req_reg, req_field, mem_rdata,
    output req_ready, mem_addr, mem_rd, mem_wr, mem_wdata, done, err
  );

  modport slave (
    output req_valid, req_addr, req_reg, req_field, mem_rdata,
    input  req_ready, mem_addr, mem_rd, mem_wr, mem_wdata, done, err
  );

endinterface

// File: rtl/fieldS.sv
// Field-store merge: bytes max(L,1)..R of the old word take the register's
// rightmost bytes, the sign is replaced only when L=0. An invalid field
// leaves the old word untouched.
module fieldS
  import mix_pkg::*;
(
  input  logic [MixWordW-1:0] in_word,
  input  logic [MixWordW-1:0] data_word,
  input  logic [5:0]          field,
  output logic [MixWordW-1:0] out_word
);

  logic [2:0] fl;
  logic [2:0] fr;
  logic [2:0] first;

  // Combinational byte merge
  always_comb begin
    fl       = field[5:3];
    fr       = field[2:0];
    first    = (fl == 3'd0) ? 3'd1 : fl;
    out_word = data_word;
    if (field_ok(field)) begin
      if (fl == 3'd0) begin
        out_word[SignBit] = in_word[SignBit];
      end
      for (int unsigned b = 1; b <= NumBytes; b++) begin
        // Target byte b pulls register byte 5-(R-b), right-aligning the source
        if (b >= 32'(first) && b <= 32'(fr)) begin
          out_word[byte_lsb(b) +: ByteW] =
            in_word[byte_lsb(NumBytes - (32'(fr) - b)) +: ByteW];
        end
      end
    end
  end

endmodule

// File: rtl/store_seq.sv
// MIX memory-store sequencer: read-modify-write for partial fields, a single
// write for the full word (0:5).
// Optional macro STORE_FCHK_EN: reject fields with L>R or R>5 in IDLE,
// pulsing err with done and touching no memory.
module store_seq
  import mix_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned WORD_W = 31
) (
  input logic         clk,
  input logic         rst_n,
  store_seq_if.master bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] reg_q;
  logic [WORD_W-1:0] data_q;
  logic [5:0]        field_q;
  logic              done_q;
  logic              accept;
  logic              fchk_bad;
  logic [WORD_W-1:0] merged;

  fieldS u_fields (
    .in_word  (reg_q),
    .data_word(data_q),
    .field    (field_q),
    .out_word (merged)
  );

  // Next-state logic and request acceptance
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    fchk_bad = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          accept = 1'b1;
`ifdef STORE_FCHK_EN
          if (!field_ok(bus.req_field)) begin
            fchk_bad = 1'b1;
            state_d  = StIdle;
          end else
`endif
          if (bus.req_field == FULL_FIELD) begin
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead:  state_d = StWait;
      StWait:  state_d = StWrite;
      StWrite: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register; reset aborts any in-flight store
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latches, read-data capture and the completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      reg_q   <= '0;
      field_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= bus.req_addr;
        reg_q   <= bus.req_reg;
        field_q <= bus.req_field;
      end
      if (state_q == StWait) begin
        data_q <= bus.mem_rdata;
      end
      done_q <= (state_q == StWrite) || fchk_bad;
    end
  end

`ifdef STORE_FCHK_EN
  logic err_q;

  // Invalid-field flag, pulses alongside done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= fchk_bad;
    end
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // Memory strobes; write data depends only on registered state, never on
  // mem_rdata, and every output is zero outside its strobe
  always_comb begin
    bus.req_ready = (state_q == StIdle);
    bus.mem_rd    = (state_q == StRead);
    bus.mem_wr    = (state_q == StWrite);
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.done      = done_q;
    if (bus.mem_rd || bus.mem_wr) begin
      bus.mem_addr = addr_q;
    end
    if (bus.mem_wr) begin
      bus.mem_wdata = (field_q == FULL_FIELD) ? reg_q : merged;
    end
  end

endmodule
